// File: rtl/binary_counter3_pkg.sv
// ============================================================================
// Module      : binary_counter3_pkg
// Description : Shared defaults and direction encoding for binary_counter3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package binary_counter3_pkg;

   localparam int WIDTH_DEF     = 3;
   localparam int RESET_VAL_DEF = 0;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

endpackage : binary_counter3_pkg

`default_nettype wire

// File: rtl/binary_counter3_next.sv
// ============================================================================
// Module      : binary_counter3_next
// Description : Next-state value for the counter: reset > load > step > hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_counter3_next
   import binary_counter3_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int RESET_VAL = RESET_VAL_DEF
) (
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             enable_i,
   input  dir_e             dir_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic [WIDTH-1:0] cnt_i,
   output logic [WIDTH-1:0] cnt_o
);

   localparam logic [WIDTH-1:0] c_RESET_VAL = RESET_VAL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] c_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] w_inc;
   logic [WIDTH-1:0] w_dec;

   // Carry/borrow drop out naturally from the WIDTH-bit result.
   assign w_inc = cnt_i + c_ONE;
   assign w_dec = cnt_i - c_ONE;

   always_comb begin
      cnt_o = cnt_i;
      if (rst_i) begin
         cnt_o = c_RESET_VAL;
      end else if (load_i) begin
         cnt_o = load_val_i;
      end else if (enable_i) begin
         cnt_o = (dir_i == DIR_UP) ? w_inc : w_dec;
      end
   end

endmodule : binary_counter3_next

`default_nettype wire

// File: rtl/binary_counter3.sv
// ============================================================================
// Module      : binary_counter3
// Description : Loadable up/down binary counter with optional terminal-count
//               flag, enabled by defining BINARY_COUNTER3_TC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_counter3
   import binary_counter3_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int RESET_VAL = RESET_VAL_DEF
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             ENABLE,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOAD_VAL,
   input  logic             UP_DN,
   output logic [WIDTH-1:0] ctr3,
   output logic             TC
);

   logic [WIDTH-1:0] ctr3_q;
   logic [WIDTH-1:0] ctr3_d;

   binary_counter3_next #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_next (
      .rst_i      (RESET),
      .load_i     (LOAD),
      .enable_i   (ENABLE),
      .dir_i      (dir_e'(UP_DN)),
      .load_val_i (LOAD_VAL),
      .cnt_i      (ctr3_q),
      .cnt_o      (ctr3_d)
   );

   always_ff @(posedge CLOCK) begin
      ctr3_q <= ctr3_d;
   end

   assign ctr3 = ctr3_q;

`ifdef BINARY_COUNTER3_TC_EN
   // Flags the wrap that the next enabled edge will perform.
   assign TC = ENABLE & ~LOAD & ~RESET &
               (UP_DN ? (ctr3_q == {WIDTH{1'b1}}) : (ctr3_q == {WIDTH{1'b0}}));
`else
   assign TC = 1'b0;
`endif

endmodule : binary_counter3

`default_nettype wire

// File: tb/tb_binary_counter3.sv
// ============================================================================
// Module      : tb_binary_counter3
// Description : Directed and randomized checks of binary_counter3 against a
//               modular-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_binary_counter3;

   localparam int W   = 3;
   localparam int MOD = 1 << W;

   logic         CLOCK = 1'b0;
   logic         RESET = 1'b0;
   logic         ENABLE = 1'b0;
   logic         LOAD = 1'b0;
   logic [W-1:0] LOAD_VAL = '0;
   logic         UP_DN = 1'b1;
   logic [W-1:0] ctr3;
   logic         TC;

   int tests = 0;
   int fails = 0;
   int model = 0;

   binary_counter3 dut (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .ENABLE   (ENABLE),
      .LOAD     (LOAD),
      .LOAD_VAL (LOAD_VAL),
      .UP_DN    (UP_DN),
      .ctr3     (ctr3),
      .TC       (TC)
   );

   always #5 CLOCK = ~CLOCK;

   function automatic bit tc_expect(bit rst, bit ld, bit en, bit up, int m);
`ifdef BINARY_COUNTER3_TC_EN
      return en && !ld && !rst && ((up && m == MOD - 1) || (!up && m == 0));
`else
      return 1'b0;
`endif
   endfunction

   // Apply controls mid-cycle, check TC before the edge and ctr3 after it.
   task automatic step(input string tag, input bit rst, input bit ld,
                       input bit en, input bit up, input int lv);
      @(negedge CLOCK);
      RESET = rst; LOAD = ld; ENABLE = en; UP_DN = up; LOAD_VAL = lv[W-1:0];
      #1;
      if (model >= 0) begin
         tests++;
         assert (TC === tc_expect(rst, ld, en, up, model)) else begin
            fails++;
            $error("FAIL %s TC: got %b expected %b", tag, TC, tc_expect(rst, ld, en, up, model));
         end
      end
      @(posedge CLOCK);
      if (rst)       model = 0;
      else if (ld)   model = lv % MOD;
      else if (en)   model = up ? (model + 1) % MOD : (model + MOD - 1) % MOD;
      #1;
      tests++;
      assert (ctr3 === model[W-1:0]) else begin
         fails++;
         $error("FAIL %s ctr3: got %0d expected %0d", tag, ctr3, model);
      end
   endtask

   initial begin
      model = -1;
      // Reset with ENABLE low, then hold for three edges.
      step("reset", 1, 0, 0, 1, 0);
      tests++;
      assert (TC === 1'b0) else begin
         fails++;
         $error("FAIL reset_tc: got %b expected 0", TC);
      end
      for (int i = 0; i < 3; i++) step("hold", 0, 0, 0, 1, 0);

      // Count up ten edges through the wrap.
      for (int i = 0; i < 10; i++) step("up", 0, 0, 1, 1, 0);
      tests++;
      assert (ctr3 === 3'd2) else begin
         fails++;
         $error("FAIL up_end: got %0d expected 2", ctr3);
      end

      // Count down from zero.
      step("reset2", 1, 0, 1, 0, 0);
      step("down7", 0, 0, 1, 0, 0);
      step("down6", 0, 0, 1, 0, 0);
      tests++;
      assert (ctr3 === 3'd6) else begin
         fails++;
         $error("FAIL down_end: got %0d expected 6", ctr3);
      end

      // Load wins over enable, then resume counting.
      step("load5", 0, 1, 1, 0, 5);
      step("after_load", 0, 0, 1, 1, 0);
      tests++;
      assert (ctr3 === 3'd6) else begin
         fails++;
         $error("FAIL after_load_end: got %0d expected 6", ctr3);
      end

      // Reset beats load at count 4.
      step("load4", 0, 1, 0, 1, 4);
      step("rst_load", 1, 1, 1, 1, 3);
      step("post_rst", 0, 0, 1, 1, 0);
      tests++;
      assert (ctr3 === 3'd1) else begin
         fails++;
         $error("FAIL post_rst_end: got %0d expected 1", ctr3);
      end

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step("rand",
              ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) != 0),
              $urandom_range(0, 1),
              $urandom_range(0, MOD - 1));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_binary_counter3

`default_nettype wire

// File: doc/binary_counter3.md
BINARY_COUNTER3 -- requirements
Module: binary_counter3

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits; legal range 2..16.
REQ-002 Parameter RESET_VAL, default 0: value loaded into ctr3 on reset; must fit in WIDTH bits.
REQ-003 Port CLOCK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port ENABLE, input, 1 bit: count enable; 1 = step the counter each rising edge, 0 = hold.
REQ-006 Port LOAD, input, 1 bit: synchronous parallel load strobe.
REQ-007 Port LOAD_VAL, input, WIDTH bits: value taken by ctr3 when LOAD=1.
REQ-008 Port UP_DN, input, 1 bit: count direction; 1 = up, 0 = down.
REQ-009 Port ctr3, output, WIDTH bits: registered counter value.
REQ-010 Port TC, output, 1 bit: terminal-count flag (see Configuration).

Function
REQ-011 ctr3 SHALL update only on the rising edge of CLOCK, with this priority: RESET, then LOAD, then ENABLE.
REQ-012 When RESET=0 and LOAD=1, ctr3 SHALL take LOAD_VAL on that edge, regardless of ENABLE and UP_DN.
REQ-013 When RESET=0, LOAD=0, ENABLE=1 and UP_DN=1, ctr3 SHALL increment by 1 modulo 2^WIDTH; 2^WIDTH-1 wraps to 0.
REQ-014 When RESET=0, LOAD=0, ENABLE=1 and UP_DN=0, ctr3 SHALL decrement by 1 modulo 2^WIDTH; 0 wraps to 2^WIDTH-1.
REQ-015 When RESET=0, LOAD=0 and ENABLE=0, ctr3 SHALL hold its value indefinitely.
REQ-016 Latency: a change on any control input SHALL affect ctr3 at the first rising edge at which it is sampled, with no further pipeline delay.
REQ-017 Changing UP_DN while ENABLE=1 SHALL take effect at the next edge; there are no glitches or skipped values.
REQ-018 All arithmetic SHALL be unsigned and WIDTH bits wide, with the carry/borrow discarded.

Reset
REQ-019 RESET=1 at a rising edge SHALL set ctr3 to RESET_VAL, overriding LOAD and ENABLE.
REQ-020 Asserting RESET mid-count SHALL take effect at the next edge; counting resumes from RESET_VAL on the first edge after release, if ENABLE=1.
REQ-021 Before the first reset, ctr3 is undefined; TC SHALL be 0 during and immediately after reset.

Configuration
REQ-022 With macro BINARY_COUNTER3_TC_EN defined, TC SHALL be combinational and equal to 1 exactly when all of these hold: ENABLE=1, LOAD=0, RESET=0, and ctr3 is at its terminal value (2^WIDTH-1 when counting up, 0 when counting down). TC therefore flags the wrap that occurs on the next edge.
REQ-023 Without BINARY_COUNTER3_TC_EN, the TC port SHALL remain present and be tied to constant 0; counter behaviour is otherwise identical.

Structure
REQ-024 A shared package binary_counter3_pkg SHALL hold:
- the default constants WIDTH_DEF=3 and RESET_VAL_DEF=0;
- a direction enum: DIR_DOWN=0, DIR_UP=1.
REQ-025 One sub-module, binary_counter3_next, SHALL compute the next-state value (priority mux plus increment/decrement); the top module holds the register and the TC logic.

Verification
REQ-026 Reset with ENABLE=0, then hold ENABLE=0 for 3 edges -> ctr3 stays 0.
REQ-027 ENABLE=1, UP_DN=1 for 10 edges from 0 -> ctr3 = 1,2,...,7,0,1,2; TC=1 only while ctr3=7 (macro defined).
REQ-028 UP_DN=0, ENABLE=1 from 0 for 2 edges -> ctr3 = 7 then 6; TC=1 while ctr3=0.
REQ-029 LOAD=1, LOAD_VAL=5 with ENABLE=1 -> ctr3=5 on the next edge; next enabled up edge gives 6.
REQ-030 RESET=1 and LOAD=1 together at ctr3=4 -> ctr3=0; after release with ENABLE=1 -> 1.
REQ-031 Build without BINARY_COUNTER3_TC_EN, repeat REQ-027 -> identical ctr3 sequence, TC constantly 0.
